// File: rtl/modbus_tx_framer.sv
// modbus_tx_framer
//   Modbus RTU transmit frame sequencer. Payload bytes pass straight through
//   from the PDU source to the UART TX. Each accepted byte is also streamed
//   to an external registered crc16_modbus engine. After the last byte, the
//   CRC low byte and then the CRC high byte are appended, and the engine is
//   cleared. A frame is forcibly ended after MAX_PAYLOAD bytes.
//
//   Optional feature: define MODBUS_TX_GAP_EN to enforce GAP_CYCLES idle
//   clocks after each frame. Without it, CRC_HI returns straight to IDLE.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   s_data/s_valid/s_last/s_ready   payload stream from the PDU source
//   m_data/m_valid/m_ready          byte stream to the UART TX
//   crc_clr/crc_valid/crc_data      control and data to the CRC engine
//   crc_i             running CRC, valid one cycle after crc_valid
//   busy              high whenever not IDLE
//   trunc             sticky: a frame was cut at MAX_PAYLOAD
//   frame_cnt         completed frames, wraps at 2^16

module modbus_tx_framer #(
    parameter int GAP_CYCLES  = 3646,
    parameter int MAX_PAYLOAD = 254
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        crc_clr,
    output logic        crc_valid,
    output logic [7:0]  crc_data,
    input  logic [15:0] crc_i,
    output logic        busy,
    output logic        trunc,
    output logic [15:0] frame_cnt
);

`ifdef MODBUS_TX_GAP_EN
    typedef enum logic [2:0] {IDLE, PAYLOAD, CRC_LO, CRC_HI, GAP} state_t;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    logic [GW-1:0] gap_cnt;
`else
    typedef enum logic [2:0] {IDLE, PAYLOAD, CRC_LO, CRC_HI} state_t;
`endif

    state_t     state;
    logic [7:0] pay_cnt;
    logic       pass;
    logic       hs;
    logic       at_max;

    assign pass = (state == IDLE) || (state == PAYLOAD);
    assign hs   = pass && s_valid && m_ready;
    // The handshake that would bring the count to MAX_PAYLOAD ends the frame.
    assign at_max = ({1'b0, pay_cnt} + 9'd1) == 9'(MAX_PAYLOAD);

    always_comb begin
        m_data  = s_data;
        m_valid = 1'b0;
        s_ready = 1'b0;
        case (state)
            IDLE, PAYLOAD: begin
                m_valid = s_valid;
                s_ready = m_ready;
            end
            CRC_LO: begin
                m_valid = 1'b1;
                m_data  = crc_i[7:0];
            end
            CRC_HI: begin
                m_valid = 1'b1;
                m_data  = crc_i[15:8];
            end
            default: ;
        endcase
    end

    assign crc_valid = hs;
    assign crc_data  = s_data;
    // Only asserted in CRC_HI, so it can never coincide with crc_valid.
    assign crc_clr   = (state == CRC_HI) && m_ready;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pay_cnt   <= 8'd0;
            trunc     <= 1'b0;
            frame_cnt <= 16'd0;
`ifdef MODBUS_TX_GAP_EN
            gap_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE, PAYLOAD: begin
                    if (hs) begin
                        if (s_last) begin
                            state   <= CRC_LO;
                            pay_cnt <= 8'd0;
                        end else if (at_max) begin
                            state   <= CRC_LO;
                            pay_cnt <= 8'd0;
                            trunc   <= 1'b1;
                        end else begin
                            state   <= PAYLOAD;
                            pay_cnt <= pay_cnt + 8'd1;
                        end
                    end
                end
                CRC_LO: begin
                    if (m_ready) state <= CRC_HI;
                end
                CRC_HI: begin
                    if (m_ready) begin
                        frame_cnt <= frame_cnt + 16'd1;
`ifdef MODBUS_TX_GAP_EN
                        state     <= GAP;
                        gap_cnt   <= GW'(GAP_CYCLES - 1);
`else
                        state     <= IDLE;
`endif
                    end
                end
`ifdef MODBUS_TX_GAP_EN
                GAP: begin
                    if (gap_cnt == '0) state <= IDLE;
                    else               gap_cnt <= gap_cnt - 1'b1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
